fsk_symbol_scheduler: RTL

Sequences the programmable clock divider for FSK visualisation: accepts one data bit per symbol over a valid/ready handshake and drives the divider's divisor and switch inputs. Each bit holds a mark or space divisor for SYMBOL_PERIODS divided periods. The block mirrors the divider's phase counter, so divisor changes land only on period boundaries and never truncate a divided period. It sits between the bit source (pattern generator or UART rx) and the divider feeding the display path.

---
 rtl/fsk_sched_pkg.sv | 20 ++
 rtl/fsk_period_tracker.sv | 39 +++
 rtl/fsk_symbol_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fsk_sched_pkg.sv
// Shared types and helpers for the FSK symbol scheduler: state encoding,
// default widths and the divisor floor clamp.
package fsk_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DIV_W_DEF   = 32;
  localparam int MIN_DIV_DEF = 2;
  localparam int CLAMP_W     = 64;

  // Operates on a wide container so any DIV_W up to CLAMP_W can use it.
  function automatic logic [CLAMP_W-1:0] clamp_div(input logic [CLAMP_W-1:0] sel,
                                                  input logic [CLAMP_W-1:0] floor_v);
    return (sel < floor_v) ? floor_v : sel;
  endfunction

endpackage

// File: rtl/fsk_period_tracker.sv
// Mirror of the divider phase counter plus a divided-period counter; flags
// the end of each divided period (bnd) and the end of each symbol (last).
module fsk_period_tracker
  import fsk_sched_pkg::*;
#(
  parameter int DIV_W          = DIV_W_DEF,
  parameter int SYMBOL_PERIODS = 8
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             i_run,
  input  logic             i_clear,
  input  logic [DIV_W-1:0] i_divisor,
  output logic             o_bnd,
  output logic             o_last
);

  localparam int PER_W = (SYMBOL_PERIODS > 1) ? $clog2(SYMBOL_PERIODS) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SYMBOL_PERIODS - 1);

  logic [DIV_W-1:0] r_ph_cnt;
  logic [PER_W-1:0] r_per_cnt;

  assign o_bnd  = i_run && (r_ph_cnt >= (i_divisor - DIV_W'(1)));
  assign o_last = o_bnd && (r_per_cnt == PER_LAST);

  always_ff @(posedge clk_in) begin
    if (!reset_n || i_clear) begin
      r_ph_cnt  <= '0;
      r_per_cnt <= '0;
    end else if (i_run) begin
      r_ph_cnt <= o_bnd ? '0 : r_ph_cnt + DIV_W'(1);
      if (o_bnd) begin
        r_per_cnt <= o_last ? '0 : r_per_cnt + PER_W'(1);
      end
    end
  end

endmodule

// File: rtl/fsk_symbol_scheduler.sv
// Feeds a programmable divider with mark/space divisors, one symbol per bit,
// switching only on divided-period boundaries. Optional FSK_IDLE_TONE_EN keeps
// the line on the space tone instead of stopping when no bit is waiting.
module fsk_symbol_scheduler
  import fsk_sched_pkg::*;
#(
  parameter int SYMBOL_PERIODS = 8,
  parameter int DIV_W          = DIV_W_DEF,
  parameter int MIN_DIV        = MIN_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] mark_div,
  input  logic [DIV_W-1:0] space_div,
  input  logic             sym_valid,
  input  logic             sym_bit,
  output logic             sym_ready,
  output logic [DIV_W-1:0] divisor_out,
  output logic             switch_out,
  output logic             busy,
  output logic             sym_done,
  output logic             underrun
);

  state_t           r_state;
  logic [DIV_W-1:0] r_divisor;
  logic             r_switch;
  logic             r_sym_done;
  logic             r_underrun;

  state_t           w_state_nxt;
  logic [DIV_W-1:0] w_divisor_nxt;
  logic             w_switch_nxt;
  logic             w_sym_done_nxt;
  logic             w_underrun_nxt;
  logic             w_clear;
  logic             w_bnd;
  logic             w_last;
  logic             w_accept;
  logic [DIV_W-1:0] w_sel_clamped;

  assign w_sel_clamped = DIV_W'(clamp_div(CLAMP_W'(sym_bit ? mark_div : space_div),
                                          CLAMP_W'(MIN_DIV)));

`ifdef FSK_IDLE_TONE_EN
  logic [DIV_W-1:0] w_space_clamped;
  assign w_space_clamped = DIV_W'(clamp_div(CLAMP_W'(space_div), CLAMP_W'(MIN_DIV)));
`endif

  fsk_period_tracker #(
    .DIV_W          (DIV_W),
    .SYMBOL_PERIODS (SYMBOL_PERIODS)
  ) u_tracker (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .i_run     (r_switch),
    .i_clear   (w_clear),
    .i_divisor (r_divisor),
    .o_bnd     (w_bnd),
    .o_last    (w_last)
  );

  assign sym_ready   = enable && ((r_state == IDLE) || w_last);
  assign w_accept    = sym_valid && sym_ready;
  assign divisor_out = r_divisor;
  assign switch_out  = r_switch;
  assign busy        = (r_state == RUN);
  assign sym_done    = r_sym_done;
  assign underrun    = r_underrun;

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_divisor  <= DIV_W'(MIN_DIV);
      r_switch   <= 1'b0;
      r_sym_done <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_divisor  <= w_divisor_nxt;
      r_switch   <= w_switch_nxt;
      r_sym_done <= w_sym_done_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_divisor_nxt  = r_divisor;
    w_switch_nxt   = r_switch;
    w_sym_done_nxt = 1'b0;
    w_underrun_nxt = 1'b0;
    w_clear        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_divisor_nxt = w_sel_clamped;
          w_switch_nxt  = 1'b1;
          w_clear       = 1'b1;
          w_state_nxt   = RUN;
        end
      end
      RUN: begin
        // Abort takes priority over a coincident symbol end.
        if (!enable) begin
          w_switch_nxt = 1'b0;
          w_clear      = 1'b1;
          w_state_nxt  = IDLE;
        end else if (w_last) begin
          w_sym_done_nxt = 1'b1;
          if (w_accept) begin
            w_divisor_nxt = w_sel_clamped;
          end else begin
            w_underrun_nxt = 1'b1;
`ifdef FSK_IDLE_TONE_EN
            w_divisor_nxt = w_space_clamped;
`else
            w_switch_nxt  = 1'b0;
            w_state_nxt   = IDLE;
`endif
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
